// File: rtl/rocketcpu_irqctrl_if.sv
// rtl/rocketcpu_irqctrl_if.sv - single-cycle Wishbone-style register port for the interrupt controller
interface rocketcpu_irqctrl_if;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        o_wb_ack;
    logic [31:0] o_wb_rdt;

    modport master (
        output i_wb_adr,
        output i_wb_dat,
        output i_wb_we,
        output i_wb_cyc,
        input  o_wb_ack,
        input  o_wb_rdt
    );

    modport slave (
        input  i_wb_adr,
        input  i_wb_dat,
        input  i_wb_we,
        input  i_wb_cyc,
        output o_wb_ack,
        output o_wb_rdt
    );
endinterface

// File: rtl/rocketcpu_irqctrl.sv
// rtl/rocketcpu_irqctrl.sv - edge-capturing interrupt aggregator with enable mask and claim register
module rocketcpu_irqctrl #(
    parameter int NUM_IRQ = 4
) (
    input  logic               i_wb_clk,
    input  logic               i_wb_rst,
    input  logic [NUM_IRQ-1:0] i_irq,
    rocketcpu_irqctrl_if.slave wb,
    output logic               o_irq
);

    localparam int PAD = 32 - NUM_IRQ;

    localparam logic [1:0] ADR_PENDING = 2'd0;
    localparam logic [1:0] ADR_ENABLE  = 2'd1;
    localparam logic [1:0] ADR_ACTIVE  = 2'd2;
    localparam logic [1:0] ADR_CLAIM   = 2'd3;

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c_mask;
    logic [NUM_IRQ-1:0] wr_bits;

    logic        accept;
    logic        wr_pending;
    logic        wr_enable;
    logic [4:0]  claim_idx;
    logic [31:0] claim_word;
    logic [31:0] rd_data;
    logic        unused_dat;

    assign active  = pending & enable;
    assign rise    = i_irq & ~prev;
    assign wr_bits = wb.i_wb_dat[NUM_IRQ-1:0];

    // Data bits above the implemented sources are never stored.
    assign unused_dat = ^wb.i_wb_dat[31:NUM_IRQ];

    // A held cyc is accepted only on alternate cycles because ack blocks the next accept.
    assign accept     = wb.i_wb_cyc & ~wb.o_wb_ack;
    assign wr_pending = accept & wb.i_wb_we & (wb.i_wb_adr == ADR_PENDING);
    assign wr_enable  = accept & wb.i_wb_we & (wb.i_wb_adr == ADR_ENABLE);
    assign w1c_mask   = wr_pending ? wr_bits : '0;

    // Scan downward so the lowest-numbered active source is the last to assign.
    always_comb begin
        claim_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_idx = 5'(i);
            end
        end
    end

    assign claim_word = {|active, 26'b0, claim_idx};

    always_comb begin
        rd_data = '0;
        case (wb.i_wb_adr)
            ADR_PENDING: rd_data = {{PAD{1'b0}}, pending};
            ADR_ENABLE:  rd_data = {{PAD{1'b0}}, enable};
            ADR_ACTIVE:  rd_data = {{PAD{1'b0}}, active};
            ADR_CLAIM:   rd_data = claim_word;
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        // prev tracks i_irq even in reset so a source high at release is not seen as an edge.
        prev <= i_irq;
        if (i_wb_rst) begin
            pending     <= '0;
            enable      <= '0;
            wb.o_wb_ack <= 1'b0;
            wb.o_wb_rdt <= '0;
            o_irq       <= 1'b0;
        end else begin
            // Rising edge is OR-ed after the clear so a same-cycle set wins.
            pending     <= (pending & ~w1c_mask) | rise;
            if (wr_enable) begin
                enable <= wr_bits;
            end
            wb.o_wb_ack <= accept;
            wb.o_wb_rdt <= accept ? rd_data : '0;
            o_irq       <= |active;
        end
    end

endmodule

// File: tb/tb_rocketcpu_irqctrl.sv
// tb/tb_rocketcpu_irqctrl.sv - directed self-checking bench for rocketcpu_irqctrl
module tb_rocketcpu_irqctrl;

    logic       i_wb_clk = 1'b0;
    logic       i_wb_rst;
    logic [3:0] i_irq;
    logic       o_irq;

    rocketcpu_irqctrl_if wb ();

    rocketcpu_irqctrl #(.NUM_IRQ(4)) dut (
        .i_wb_clk (i_wb_clk),
        .i_wb_rst (i_wb_rst),
        .i_irq    (i_irq),
        .wb       (wb.slave),
        .o_irq    (o_irq)
    );

    always #5 i_wb_clk = ~i_wb_clk;

    localparam logic [1:0] PENDING = 2'd0;
    localparam logic [1:0] ENABLE  = 2'd1;
    localparam logic [1:0] ACTIVE  = 2'd2;
    localparam logic [1:0] CLAIM   = 2'd3;

    int   total = 0;
    int   bad   = 0;
    logic irq_at_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One access: accepted at edge k, data sampled after k, ack verified gone after k+1.
    task automatic bus(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                       output logic [31:0] rdata);
        @(negedge i_wb_clk);
        wb.i_wb_cyc = 1'b1;
        wb.i_wb_we  = we;
        wb.i_wb_adr = adr;
        wb.i_wb_dat = dat;
        @(posedge i_wb_clk);
        #1;
        check("ack_hi", {31'b0, wb.o_wb_ack}, 32'd1);
        rdata      = wb.o_wb_rdt;
        irq_at_ack = o_irq;
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_we  = 1'b0;
        @(posedge i_wb_clk);
        #1;
        check("ack_lo", {31'b0, wb.o_wb_ack}, 32'd0);
        check("rdt_idle", wb.o_wb_rdt, 32'd0);
    endtask

    task automatic wr(input logic [1:0] adr, input logic [31:0] dat);
        logic [31:0] unused_rd;
        bus(1'b1, adr, dat, unused_rd);
    endtask

    task automatic rd(input string tag, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        bus(1'b0, adr, 32'h0, r);
        check(tag, r, exp);
    endtask

    initial begin
        i_wb_rst    = 1'b1;
        i_irq       = 4'b0001;
        wb.i_wb_cyc = 1'b1;
        wb.i_wb_we  = 1'b0;
        wb.i_wb_adr = ENABLE;
        wb.i_wb_dat = 32'h0;
        irq_at_ack  = 1'b0;

        repeat (3) @(posedge i_wb_clk);
        #1;
        check("rst_ack", {31'b0, wb.o_wb_ack}, 32'd0);
        check("rst_rdt", wb.o_wb_rdt, 32'd0);
        check("rst_irq", {31'b0, o_irq}, 32'd0);
        @(negedge i_wb_clk);
        wb.i_wb_cyc = 1'b0;
        i_wb_rst    = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge i_wb_clk);
            #1;
            check("rel_irq", {31'b0, o_irq}, 32'd0);
        end
        rd("rel_pending", PENDING, 32'h0);

        // Single-cycle pulse on source 0
        wr(ENABLE, 32'h1);
        @(negedge i_wb_clk);
        i_irq = 4'b0000;
        @(negedge i_wb_clk);
        i_irq = 4'b0001;
        @(posedge i_wb_clk);
        #1;
        check("pulse_irq_n", {31'b0, o_irq}, 32'd0);
        @(negedge i_wb_clk);
        i_irq = 4'b0000;
        @(posedge i_wb_clk);
        #1;
        check("pulse_irq_n1", {31'b0, o_irq}, 32'd1);
        rd("claim0", CLAIM, 32'h8000_0000);
        wr(PENDING, 32'h1);
        check("w1c_irq_at_ack", {31'b0, irq_at_ack}, 32'd1);
        check("w1c_irq_after", {31'b0, o_irq}, 32'd0);

        // Masked source, then enable
        wr(ENABLE, 32'h0);
        @(negedge i_wb_clk);
        i_irq = 4'b0100;
        @(posedge i_wb_clk);
        rd("mask_pending", PENDING, 32'h4);
        rd("mask_active", ACTIVE, 32'h0);
        check("mask_irq", {31'b0, o_irq}, 32'd0);
        wr(ENABLE, 32'h4);
        check("en_irq_at_ack", {31'b0, irq_at_ack}, 32'd0);
        check("en_irq_after", {31'b0, o_irq}, 32'd1);
        rd("claim2", CLAIM, 32'h8000_0002);
        wr(PENDING, 32'h4);
        rd("level_no_repend", PENDING, 32'h0);
        @(negedge i_wb_clk);
        i_irq = 4'b0000;

        // Priority among multiple pending sources
        wr(ENABLE, 32'hF);
        @(negedge i_wb_clk);
        i_irq = 4'b1010;
        @(negedge i_wb_clk);
        i_irq = 4'b0000;
        rd("prio_pending", PENDING, 32'hA);
        rd("claim_a1", CLAIM, 32'h8000_0001);
        wr(PENDING, 32'h2);
        rd("claim_a3", CLAIM, 32'h8000_0003);
        wr(PENDING, 32'h8);
        check("clr_irq_at_ack", {31'b0, irq_at_ack}, 32'd1);
        check("clr_irq_after", {31'b0, o_irq}, 32'd0);
        rd("claim_none", CLAIM, 32'h0);

        // Rise of source 1 sampled at the same edge as its W1C
        @(negedge i_wb_clk);
        i_irq       = 4'b0010;
        wb.i_wb_cyc = 1'b1;
        wb.i_wb_we  = 1'b1;
        wb.i_wb_adr = PENDING;
        wb.i_wb_dat = 32'h2;
        @(posedge i_wb_clk);
        #1;
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_we  = 1'b0;
        @(posedge i_wb_clk);
        rd("collision", PENDING, 32'h2);
        wr(PENDING, 32'h2);
        @(negedge i_wb_clk);
        i_irq = 4'b0000;

        // Held cyc reading ENABLE
        @(negedge i_wb_clk);
        wb.i_wb_cyc = 1'b1;
        wb.i_wb_we  = 1'b0;
        wb.i_wb_adr = ENABLE;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("held_ack", {31'b0, wb.o_wb_ack}, (c % 2 == 1) ? 32'd1 : 32'd0);
            check("held_rdt", wb.o_wb_rdt, (c % 2 == 1) ? 32'hF : 32'h0);
            @(negedge i_wb_clk);
        end
        wb.i_wb_cyc = 1'b0;

        // Writes to read-only registers
        i_irq = 4'b0001;
        @(negedge i_wb_clk);
        i_irq = 4'b0000;
        wr(ACTIVE, 32'h0);
        wr(CLAIM, 32'hFFFF_FFFF);
        wr(ACTIVE, 32'hFFFF_FFFF);
        rd("ro_pending", PENDING, 32'h1);
        rd("ro_enable", ENABLE, 32'hF);
        rd("ro_claim", CLAIM, 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
